cla_pipe_adder: RTL and testbench



---
 rtl/cla_pipe_pkg.sv | 17 +
 rtl/cla_pipe_adder_group4.sv | 27 ++
 rtl/cla_pipe_adder.sv | 159 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_pkg.sv
// Shared constants, types and configuration check for the pipelined CLA adder.
package cla_pipe_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pgPair_t;

    // WIDTH must split into STAGES segments that are each a whole number of groups.
    function automatic bit cfgOk(int width, int stages);
        return (stages >= 1) && (stages <= width / GROUP_W) &&
               ((width % (GROUP_W * stages)) == 0);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_group4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES segment per stage.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
    import cla_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG = WIDTH / STAGES;
    localparam int NG  = SEG / GROUP_W;

    if (!cfgOk(WIDTH, STAGES)) begin : g_badCfg
        $error("cla_pipe_adder: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0] bEff;
    logic             c0;
    logic             advance;

    assign bEff    = sub ? ~b : b;
    assign c0      = sub | cin;
    assign advance = !out_valid | out_ready;
    assign in_ready = advance;

    // Register k feeds stage k; operands ride along so later segments arrive skewed.
    logic [STAGES:1][WIDTH-1:0] rA, rB, rS;
    logic [STAGES:1]            rC, rV;
    logic [STAGES-1:0][WIDTH-1:0] nxtSum;
    logic [STAGES-1:0]            nxtC;
`ifdef CLA_PIPE_OVF_EN
    logic nxtOvf;
    logic rO;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   segA, segB, segS;
        logic             segC;
        logic [WIDTH-1:0] sumIn, nxt;
        pgPair_t [NG-1:0] grp;
        logic [NG:0]      gc;
        logic             term, carry;

        if (k == 0) begin : g_first
            assign segA  = a[0 +: SEG];
            assign segB  = bEff[0 +: SEG];
            assign segC  = c0;
            assign sumIn = '0;
        end else begin : g_later
            assign segA  = rA[k][k*SEG +: SEG];
            assign segB  = rB[k][k*SEG +: SEG];
            assign segC  = rC[k];
            assign sumIn = rS[k];
        end

        // Each group carry is a flat sum-of-products over group P/G and the stage carry-in.
        always_comb begin
            gc    = '0;
            term  = 1'b0;
            carry = 1'b0;
            gc[0] = segC;
            for (int unsigned j = 1; j <= NG; j++) begin
                term = segC;
                for (int unsigned i = 0; i < j; i++) term = term & grp[i].p;
                carry = term;
                for (int unsigned i = 0; i < j; i++) begin
                    term = grp[i].g;
                    for (int unsigned m = i + 1; m < j; m++) term = term & grp[m].p;
                    carry = carry | term;
                end
                gc[j] = carry;
            end
        end

        for (genvar g = 0; g < NG; g++) begin : g_group
            cla_group4 u_group (
                .a  (segA[g*GROUP_W +: GROUP_W]),
                .b  (segB[g*GROUP_W +: GROUP_W]),
                .ci (gc[g]),
                .s  (segS[g*GROUP_W +: GROUP_W]),
                .pg (grp[g].p),
                .gg (grp[g].g)
            );
        end

        always_comb begin
            nxt = sumIn;
            nxt[k*SEG +: SEG] = segS;
        end

        assign nxtSum[k] = nxt;
        assign nxtC[k]   = gc[NG];

`ifdef CLA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // Carry into the MSB recovered as a^b^s at that bit.
            assign nxtOvf = segA[SEG-1] ^ segB[SEG-1] ^ segS[SEG-1] ^ gc[NG];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rA <= '0;
            rB <= '0;
            rS <= '0;
            rC <= '0;
            rV <= '0;
`ifdef CLA_PIPE_OVF_EN
            rO <= 1'b0;
`endif
        end else if (advance) begin
            rV[1] <= in_valid;
            rA[1] <= a;
            rB[1] <= bEff;
            rS[1] <= nxtSum[0];
            rC[1] <= nxtC[0];
            for (int unsigned k = 2; k <= STAGES; k++) begin
                rV[k] <= rV[k-1];
                rA[k] <= rA[k-1];
                rB[k] <= rB[k-1];
                rS[k] <= nxtSum[k-1];
                rC[k] <= nxtC[k-1];
            end
`ifdef CLA_PIPE_OVF_EN
            rO <= nxtOvf;
`endif
        end
    end

    // Already-consumed operand segments and the last operand register have no reader.
    logic unusedOperandBits;
    assign unusedOperandBits = ^{rA, rB};

    assign out_valid = rV[STAGES];
    assign sum       = rS[STAGES];
    assign cout      = rC[STAGES];
`ifdef CLA_PIPE_OVF_EN
    assign ovf       = rO;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: directed cases on a 32/2 instance plus randomized sweeps over several configurations.
module tb_cla_pipe_adder;

    logic clk;
    int   nVec = 0;
    int   nMis = 0;
    bit   done [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum[63:0]} for a w-bit operation.
    function automatic logic [65:0] refAdd(int w, logic [63:0] x, logic [63:0] y, logic ci, logic s);
        logic [65:0] mask, be, tot, res;
        logic        ovfBit;
        mask = (66'd1 << w) - 66'd1;
        be   = s ? (~{2'b00, y} & mask) : {2'b00, y};
        tot  = {2'b00, x} + be + (s ? 66'd1 : {65'd0, ci});
        ovfBit = (x[w-1] == be[w-1]) && (tot[w-1] != x[w-1]);
        res = tot & mask;
        res[64] = tot[w];
        res[65] = ovfBit;
        return res;
    endfunction

    function automatic bit allDone();
        for (int i = 0; i < 5; i++) if (!done[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Directed instance, WIDTH=32, STAGES=2
    logic        rst, inValid, inReady, outValid, outReady, cin, sub, cout;
    logic [31:0] opA, opB, sum;
`ifdef CLA_PIPE_OVF_EN
    logic        ovf;
`endif

    cla_pipe_adder #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (opA),
        .b         (opB),
        .cin       (cin),
        .sub       (sub),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        inValid = 1'b1;
        opA = x;
        opB = y;
        cin = ci;
        sub = s;
    endtask

    // One beat with out_ready high: empty after one cycle, result after two.
    task automatic runOne(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s,
                          input logic [31:0] expSum, input logic expCout, input logic expOvf);
        drive(x, y, ci, s);
        @(negedge clk);
        inValid = 1'b0;
        checkEq({tag, " valid@1"}, outValid, 1'b0);
        @(negedge clk);
        checkEq({tag, " valid@2"}, outValid, 1'b1);
        checkEq({tag, " sum"}, sum, expSum);
        checkEq({tag, " cout"}, cout, expCout);
`ifdef CLA_PIPE_OVF_EN
        checkEq({tag, " ovf"}, ovf, expOvf);
`else
        if (expOvf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
    endtask

    initial begin
        int          nb, got, stalls;
        logic        stallPrev;
        logic [31:0] held;
        logic        fin;

        rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
        opA = '0; opB = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("reset out_valid", outValid, 1'b0);
        checkEq("reset sum", sum, 32'h0);
        checkEq("reset cout", cout, 1'b0);
        rst = 1'b0;
        #1;
        checkEq("in_ready after reset", inReady, 1'b1);
        @(negedge clk);

        runOne("cross carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        runOne("sub borrow", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runOne("sub noborrow", 32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
        runOne("cin add", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: out_ready low in cycles 3..5
        nb = 0; got = 0; stalls = 0; stallPrev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            outReady = !(cyc >= 3 && cyc <= 5);
            inValid  = (nb < 4);
            opA = nb + 1; opB = nb + 1; cin = 1'b0; sub = 1'b0;
            #1;
            if (stallPrev) begin
                checkEq("bp hold valid", outValid, 1'b1);
                checkEq("bp hold sum", sum, held);
            end
            checkEq("bp in_ready", inReady, !(outValid && !outReady));
            if (!inReady) stalls++;
            if (outValid && outReady) begin
                checkEq("bp order", sum, 32'((got + 1) * 2));
                got++;
            end
            if (inValid && inReady) nb++;
            stallPrev = outValid && !outReady;
            held = sum;
            @(negedge clk);
        end
        inValid = 1'b0; outReady = 1'b1;
        checkEq("bp beats out", got, 4);
        checkEq("bp stall cycles", stalls, 3);
        @(negedge clk);

        // Async reset with two beats in flight
        drive(32'h1, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h2, 32'h2, 1'b0, 1'b0);
        @(negedge clk);
        inValid = 1'b0;
        checkEq("pre-reset valid", outValid, 1'b1);
        checkEq("pre-reset sum", sum, 32'h2);
        #2 rst = 1'b1;
        #1;
        checkEq("async rst valid", outValid, 1'b0);
        checkEq("async rst sum", sum, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        runOne("post reset", 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);
        @(negedge clk);

`ifdef CLA_PIPE_OVF_EN
        runOne("ovf pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        runOne("ovf neg", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        runOne("ovf none", 32'h3, 32'h4, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 5000 && !allDone(); t++) @(negedge clk);
        fin = allDone();
        checkEq("sweep finished", fin, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    // Randomized sweep instances
    for (genvar gi = 0; gi < 5; gi++) begin : g_sweep
        localparam int W = (gi == 4) ? 64 : 32;
        localparam int S = (gi == 4) ? 4 : (1 << gi);

        logic         rstS, ivS, irS, ovS, orS, ciS, sbS, coS;
        logic [W-1:0] aS, bS, smS;
`ifdef CLA_PIPE_OVF_EN
        logic         ofS;
`endif

        cla_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst       (rstS),
            .in_valid  (ivS),
            .in_ready  (irS),
            .a         (aS),
            .b         (bS),
            .cin       (ciS),
            .sub       (sbS),
            .out_valid (ovS),
            .out_ready (orS),
            .sum       (smS),
            .cout      (coS)
`ifdef CLA_PIPE_OVF_EN
            ,
            .ovf       (ofS)
`endif
        );

        initial begin
            logic [65:0] q[$];
            logic [65:0] r;
            logic        stallPrev;
            logic [W:0]  held;

            done[gi] = 1'b0;
            stallPrev = 1'b0;
            held = '0;
            rstS = 1'b1; ivS = 1'b0; orS = 1'b0;
            aS = '0; bS = '0; ciS = 1'b0; sbS = 1'b0;
            repeat (2) @(negedge clk);
            rstS = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (c < 350) begin
                    ivS = ($urandom_range(0, 3) != 0);
                    orS = ($urandom_range(0, 3) != 0);
                end else begin
                    ivS = 1'b0;
                    orS = 1'b1;
                end
                aS  = W'({$urandom(), $urandom()});
                bS  = W'({$urandom(), $urandom()});
                ciS = 1'($urandom_range(0, 1));
                sbS = 1'($urandom_range(0, 1));
                #1;
                if (stallPrev) begin
                    checkEq($sformatf("cfg%0d hold valid", gi), ovS, 1'b1);
                    checkEq($sformatf("cfg%0d hold data", gi), {coS, smS}, held);
                end
                checkEq($sformatf("cfg%0d in_ready", gi), irS, !(ovS && !orS));
                if (ovS && orS) begin
                    if (q.size() == 0) begin
                        checkEq($sformatf("cfg%0d spurious out", gi), ovS, 1'b0);
                    end else begin
                        r = q.pop_front();
                        checkEq($sformatf("cfg%0d sum", gi), smS, r[W-1:0]);
                        checkEq($sformatf("cfg%0d cout", gi), coS, r[64]);
`ifdef CLA_PIPE_OVF_EN
                        checkEq($sformatf("cfg%0d ovf", gi), ofS, r[65]);
`endif
                    end
                end
                if (ivS && irS) q.push_back(refAdd(W, 64'(aS), 64'(bS), ciS, sbS));
                stallPrev = ovS && !orS;
                held = {coS, smS};
                @(negedge clk);
            end
            checkEq($sformatf("cfg%0d drained", gi), q.size(), 0);
            done[gi] = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
